// File: rtl/dsp_addsub_seq.sv
// Multi-cycle wide add/subtract: 32-bit slices LSB-first through one DSP-style adder, carry chained.
// Optional macro DSP_ADDSUB_SATURATE_EN clamps the result on signed overflow.

// Stands in for the MAC16 in 32-bit adder mode with all registers bypassed.
module dsp_addsub_seq_add32 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_ci,
    output logic [31:0] o_s,
    output logic        o_co
);
    assign {o_co, o_s} = {1'b0, i_a} + {1'b0, i_b} + {32'b0, i_ci};
endmodule

module dsp_addsub_seq #(
    parameter int WIDTH = 64
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry_out,
    output logic             o_overflow
);
    localparam int SLICES = WIDTH / 32;
    localparam int IDXW   = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(SLICES - 1);

    generate
        if ((WIDTH % 32) != 0 || WIDTH < 32) begin : g_bad_width
            $error("dsp_addsub_seq: WIDTH must be a multiple of 32 and >= 32");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t            r_state, w_next;
    logic [WIDTH-1:0]  r_a, r_b, r_result;
    logic              r_op, r_carry, r_done, r_cout, r_ovf;
    logic [IDXW-1:0]   r_idx;

    logic [31:0]       w_a_sl, w_b_sl, w_sum;
    logic              w_co, w_last, w_ovf;

    always_comb begin
        w_a_sl = '0;
        w_b_sl = '0;
        for (int k = 0; k < SLICES; k++) begin
            if (r_idx == IDXW'(k)) begin
                w_a_sl = r_a[32*k +: 32];
                w_b_sl = r_b[32*k +: 32];
            end
        end
    end

    // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
    dsp_addsub_seq_add32 u_add (
        .i_a  (w_a_sl),
        .i_b  (r_op ? ~w_b_sl : w_b_sl),
        .i_ci (r_carry),
        .o_s  (w_sum),
        .o_co (w_co)
    );

    assign w_last = (r_idx == LAST);
    assign w_ovf  = (r_a[WIDTH-1] == (r_b[WIDTH-1] ^ r_op)) && (w_sum[31] != r_a[WIDTH-1]);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (i_start) w_next = RUN;
            RUN:  if (w_last)  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= 1'b0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (i_start) begin
                    r_a     <= i_a;
                    r_b     <= i_b;
                    r_op    <= i_op;
                    r_idx   <= '0;
                    r_carry <= i_op;
                end
            end else begin
                r_carry <= w_co;
                r_idx   <= r_idx + 1'b1;
                for (int k = 0; k < SLICES; k++) begin
                    if (r_idx == IDXW'(k)) r_result[32*k +: 32] <= w_sum;
                end
                if (w_last) begin
                    r_cout <= w_co;
                    r_ovf  <= w_ovf;
                    r_done <= 1'b1;
`ifdef DSP_ADDSUB_SATURATE_EN
                    if (w_ovf)
                        r_result <= r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                 : {1'b0, {(WIDTH-1){1'b1}}};
`endif
                end
            end
        end
    end

    assign o_busy      = (r_state == RUN);
    assign o_done      = r_done;
    assign o_result    = r_result;
    assign o_carry_out = r_cout;
    assign o_overflow  = r_ovf;
endmodule

// File: tb/tb_dsp_addsub_seq.sv
// Randomised bench for dsp_addsub_seq with an arithmetic reference model and directed corner cases.
module tb_dsp_addsub_seq;
    localparam int W = 64;
    localparam int SL = W / 32;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         v;
    } res_t;

    logic         i_clk = 0, i_rst_n = 0, i_start = 0, i_op = 0;
    logic [W-1:0] i_a = '0, i_b = '0;
    logic         o_busy, o_done, o_carry_out, o_overflow;
    logic [W-1:0] o_result;

    int total = 0, bad = 0;
    bit chk_en = 0;

    dsp_addsub_seq #(.WIDTH(W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_op(i_op),
        .i_a(i_a), .i_b(i_b), .o_busy(o_busy), .o_done(o_done),
        .o_result(o_result), .o_carry_out(o_carry_out), .o_overflow(o_overflow)
    );

    always #5 i_clk = ~i_clk;

    function automatic res_t calc(input bit op, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t x;
        logic [W:0] s;
        if (!op) begin
            s   = {1'b0, a} + {1'b0, b};
            x.c = s[W];
            x.r = s[W-1:0];
            x.v = (a[W-1] == b[W-1]) && (x.r[W-1] != a[W-1]);
        end else begin
            s   = {1'b0, a} - {1'b0, b};
            x.c = (a >= b);
            x.r = s[W-1:0];
            x.v = (a[W-1] != b[W-1]) && (x.r[W-1] != a[W-1]);
        end
`ifdef DSP_ADDSUB_SATURATE_EN
        if (x.v) x.r = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        return x;
    endfunction

    // Model: an accepted start schedules done SL edges later; results hold from done onward.
    int   m_left = 0;
    bit   m_done = 0, m_hold = 1;
    res_t m_pend, m_held;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_left = 0; m_done = 0; m_hold = 1;
            m_held = '{r: '0, c: 1'b0, v: 1'b0};
        end else begin
            m_done = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1; m_held = m_pend; m_hold = 1;
                end
            end else if (i_start) begin
                m_left = SL; m_pend = calc(i_op, i_a, i_b); m_hold = 0;
            end
        end
    end

    always @(negedge i_clk) begin
        if (chk_en) begin
            total++;
            if (o_busy !== (m_left > 0) || o_done !== m_done) begin
                bad++;
                $display("FAIL hs: busy=%b done=%b want busy=%b done=%b t=%0t",
                         o_busy, o_done, m_left > 0, m_done, $time);
            end
            if (m_hold) begin
                total++;
                if (o_result !== m_held.r || o_carry_out !== m_held.c || o_overflow !== m_held.v) begin
                    bad++;
                    $display("FAIL res: got %h c%b v%b want %h c%b v%b t=%0t",
                             o_result, o_carry_out, o_overflow, m_held.r, m_held.c, m_held.v, $time);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic launch(input bit op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge i_clk); #1;
        i_start = 1; i_op = op; i_a = a; i_b = b;
        @(posedge i_clk); #1;
        i_start = 0;
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            if (o_done) return;
        end
        total++; bad++;
        $display("FAIL %s: timeout waiting for done", nm);
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge i_clk);
            if (o_done) cnt++;
        end
    endtask

    initial begin
        int n;
        #12;
        chk("rst_busy", {63'b0, o_busy}, 0);
        chk("rst_done", {63'b0, o_done}, 0);
        chk("rst_res", o_result, 0);
        chk("rst_flags", {62'b0, o_carry_out, o_overflow}, 0);
        @(posedge i_clk); #3 i_rst_n = 1;
        chk_en = 1;

        // 1: carry across slice boundary, busy counted by the model
        launch(0, 64'h00000000_FFFFFFFF, 64'd1);
        wait_done("t1");
        chk("t1_res", o_result, 64'h00000001_00000000);
        chk("t1_cv", {62'b0, o_carry_out, o_overflow}, 0);

        // 2: subtract with borrow, then equal operands
        launch(1, 64'd0, 64'd1);
        wait_done("t2a");
        chk("t2a_res", o_result, 64'hFFFFFFFF_FFFFFFFF);
        chk("t2a_cv", {62'b0, o_carry_out, o_overflow}, 0);
        launch(1, 64'd5, 64'd5);
        wait_done("t2b");
        chk("t2b_res", o_result, 64'd0);
        chk("t2b_c", {63'b0, o_carry_out}, 1);

        // 3: signed overflow
        launch(0, 64'h7FFFFFFF_FFFFFFFF, 64'd1);
        wait_done("t3");
`ifdef DSP_ADDSUB_SATURATE_EN
        chk("t3_res", o_result, 64'h7FFFFFFF_FFFFFFFF);
`else
        chk("t3_res", o_result, 64'h80000000_00000000);
`endif
        chk("t3_v", {63'b0, o_overflow}, 1);

        // 4: start while busy is ignored
        @(posedge i_clk); #1;
        i_start = 1; i_op = 0; i_a = 3; i_b = 4;
        @(posedge i_clk); #1;
        i_a = 100; i_b = 1;
        @(posedge i_clk); #1;
        i_start = 0;
        count_done(8, n);
        chk("t4_ndone", 64'(n), 1);
        chk("t4_res", o_result, 64'd7);

        // 5: reset in RUN cancels the operation
        launch(0, 64'd9, 64'd9);
        #2 i_rst_n = 0;
        #1;
        chk("t5_busy", {63'b0, o_busy}, 0);
        chk("t5_res", o_result, 0);
        chk("t5_flags", {61'b0, o_done, o_carry_out, o_overflow}, 0);
        @(posedge i_clk); #3 i_rst_n = 1;
        count_done(6, n);
        chk("t5_ndone", 64'(n), 0);
        launch(0, 64'd1, 64'd1);
        wait_done("t5b");
        chk("t5b_res", o_result, 64'd2);

        // 6: start accepted in the done cycle
        launch(0, 64'd2, 64'd3);
        wait_done("t6a");
        chk("t6a_res", o_result, 64'd5);
        i_start = 1; i_op = 1; i_a = 10; i_b = 4;
        @(posedge i_clk); #1;
        i_start = 0;
        wait_done("t6b");
        chk("t6b_res", o_result, 64'd6);
        chk("t6b_c", {63'b0, o_carry_out}, 1);

        // random traffic including starts while busy and corner operands
        for (int i = 0; i < 800; i++) begin
            @(posedge i_clk); #1;
            i_start = ($urandom_range(0, 2) == 0);
            i_op    = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: i_a = {1'b0, {63{1'b1}}};
                1: i_a = {1'b1, 63'b0};
                default: i_a = {$urandom, $urandom};
            endcase
            case ($urandom_range(0, 5))
                0: i_b = 64'd1;
                1: i_b = '1;
                2: i_b = {32'd0, $urandom};
                default: i_b = {$urandom, $urandom};
            endcase
        end
        i_start = 0;
        repeat (5) @(posedge i_clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dsp_addsub_seq.md
Name: dsp_addsub_seq

Overview:
- Parametrised, multi-cycle add/subtract unit for operands wider than one DSP slice.
- Processes 32-bit slices LSB-first, one per clock, through a single SB_MAC16 configured as a 32-bit adder, with the carry chained between slices.
- Provides a start/busy/done handshake, carry/borrow out and signed overflow.
- Used by the processor's wide-arithmetic path; generalises the fixed 32-bit combinational DSP add/sub to any width and to a runtime-selectable operation.

Parameters:
- WIDTH, 64, operand/result width in bits; must be a multiple of 32 and >= 32. Compile-time error otherwise.
- SLICES, WIDTH/32, derived localparam (not overridable); number of 32-bit slices.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when idle.
- op  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while slices are being processed.
- done  output  1  one-cycle pulse; result, carry_out and overflow are valid.
- result  output  WIDTH  sum or difference, modulo 2^WIDTH.
- carry_out  output  1  add: carry out of the MSB. Sub: 1 iff a >= b unsigned (no borrow).
- overflow  output  1  signed two's-complement overflow of the full-width operation.

Behaviour:
- Reset (async, rst_n low): state=IDLE; busy=0, done=0, result=0, carry_out=0, overflow=0; slice index=0, internal carry=0, operand latches=0. Takes effect immediately, including mid-operation; a cancelled operation never produces done.
- FSM states: IDLE, RUN.
- IDLE: on an edge with start=1, latch a, b and op; slice_idx=0; carry_in = op (sub is computed as a + ~b + 1); go to RUN.
- RUN: each edge computes slice k = a[k] + (op ? ~b[k] : b[k]) + carry, writes result[32k+31:32k], stores the slice carry-out as the next carry, and increments slice_idx.
- Last slice (k = SLICES-1):
  - carry_out = final carry.
  - overflow = (sA == sB') && (sR != sA), where sA = MSB of a, sB' = MSB of the effective b, sR = MSB of result.
  - done=1 for exactly the following cycle; state goes to IDLE.
- busy = (state == RUN).
- Latency: start edge + SLICES edges. done is high in the cycle after edge SLICES counted from the start edge (SLICES cycles of busy). Throughput is one operation per SLICES+1 cycles when back-to-back.
- start while busy: ignored; the operation in flight is unaffected and the latched operands do not change.
- start in the done cycle: state is already IDLE, so it is accepted. done still drops after one cycle.
- result/carry_out/overflow: stable from done until the first RUN edge of the next operation. During RUN, result is partially updated and is not valid.
- Inputs a, b and op may change freely after the start edge.
- WIDTH=32: single RUN cycle; the behaviour is otherwise identical.
- DSP instance: registers bypassed (combinational), 32-bit adder mode, CI driven by the chained carry, CO taken as the slice carry. The DSP-internal subtract mode is not used.

Optional Feature:
- Macro: DSP_ADDSUB_SATURATE_EN.
- Defined: when overflow would be 1 at the last slice, result is replaced in the same edge:
  - 0x7FF..F if sA = 0.
  - 0x800..0 if sA = 1.
  - overflow still reports 1; carry_out is unchanged.
- Not defined: result wraps modulo 2^WIDTH; no saturation logic is synthesised.

Test Plan:
1. WIDTH=64, add: a=0x00000000_FFFFFFFF, b=1, start for 1 cycle.
   Required: busy high 2 cycles, then done pulse; result=0x00000001_00000000, carry_out=0, overflow=0.
2. Sub: a=0, b=1.
   Required: result=0xFFFFFFFF_FFFFFFFF, carry_out=0, overflow=0. Then sub a=5, b=5: result=0, carry_out=1.
3. Add: a=0x7FFFFFFF_FFFFFFFF, b=1.
   Required without the macro: result=0x80000000_00000000, overflow=1.
   Required with DSP_ADDSUB_SATURATE_EN: result=0x7FFFFFFF_FFFFFFFF, overflow=1.
4. Start an add 3+4. Pulse start with a=100, b=1 while busy.
   Required: single done; result=7. The second request produces no done.
5. Drop rst_n for 1 cycle during RUN.
   Required: busy/done/result/carry_out/overflow=0 immediately; no done afterwards. The next start of 1+1 gives result=2.
6. Assert start in the done cycle: add 2+3, then sub 10-4 held on start.
   Required: done pulses with result=5, then after SLICES more cycles done pulses with result=6, carry_out=1.
